// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and the
// round-robin search used by rr_pick.
package fifo_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Widest requester vector the search supports.
  localparam int unsigned RR_MAX_REQ = 8;

  // Return the first index at or after last+1 (mod num) whose req bit is set.
  // Returns 0 when nothing is requesting; callers qualify with |req.
  function automatic logic [2:0] rr_search(input logic [7:0]  req,
                                           input logic [2:0]  last,
                                           input int unsigned num);
    int unsigned pos;
    logic [2:0]  idx;
    logic        found;
    idx   = 3'd0;
    found = 1'b0;
    for (int unsigned i = 1; i <= RR_MAX_REQ; i++) begin
      pos = 32'(last) + i;
      if (pos >= num) begin
        pos = pos - num;
      end else begin
        pos = pos;
      end
      if ((i <= num) && !found && req[pos[2:0]]) begin
        idx   = pos[2:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: one-hot grant and index of the first
// requester after the previous owner.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  logic [7:0] req_ext;
  logic [2:0] last_ext;
  logic [2:0] pick;

  // Widen to the search width, pick the winner, and decode it to one-hot.
  always_comb begin
    req_ext                = 8'd0;
    req_ext[NUM_REQ-1:0]   = req;
    last_ext               = 3'd0;
    last_ext[IW-1:0]       = last;
    pick                   = rr_search(req_ext, last_ext, NUM_REQ);
    idx                    = pick[IW-1:0];
    grant                  = {NUM_REQ{1'b0}};
    if (|req) begin
      grant[idx] = 1'b1;
    end else begin
      grant = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter funnelling NUM_REQ word sources into one FIFO write
// port, granting bursts of up to MAX_BURST words. Define FIFO_WR_ARB_CNT_EN
// to add per-requester 16-bit word counters on o_word_cnt.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATASIZE  = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*DATASIZE-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ack,
  input  logic                         i_full,
  output logic                         o_wr_en,
  output logic [DATASIZE-1:0]          o_wr_data,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_busy
`ifdef FIFO_WR_ARB_CNT_EN
  , output logic [NUM_REQ*16-1:0]      o_word_cnt
`endif
);

  localparam int unsigned   IW        = $clog2(NUM_REQ);
  localparam int unsigned   CW        = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BURST_LEN = CW'(MAX_BURST);

  logic [0:0]         state;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      last;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_inc;
  logic               owner_req;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_pick (
    .req   (i_req),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign o_busy = (state == ST_BURST);

  // Write path: owner's word passes when it has one and the FIFO has room.
  always_comb begin
    owner_req = |(i_req & o_grant);
    cnt_inc   = cnt + CW'(1);
    o_wr_data = {DATASIZE{1'b0}};
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      o_wr_data = o_wr_data | (i_req_data[k*DATASIZE +: DATASIZE] & {DATASIZE{o_grant[k]}});
    end
    if (state == ST_BURST) begin
      o_wr_en   = owner_req & ~i_full;
      o_req_ack = o_grant & {NUM_REQ{owner_req & ~i_full}};
    end else begin
      o_wr_en   = 1'b0;
      o_req_ack = {NUM_REQ{1'b0}};
    end
  end

  // Grant FSM: pick an owner in IDLE, release it when its burst ends or it runs dry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      o_grant <= {NUM_REQ{1'b0}};
      gidx    <= {IW{1'b0}};
      cnt     <= {CW{1'b0}};
      last    <= IW'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|i_req) begin
            state   <= ST_BURST;
            o_grant <= pick_grant;
            gidx    <= pick_idx;
            cnt     <= {CW{1'b0}};
          end
        end
        ST_BURST: begin
          if (!owner_req) begin
            state   <= ST_IDLE;
            o_grant <= {NUM_REQ{1'b0}};
            last    <= gidx;
          end else if (o_wr_en) begin
            cnt <= cnt_inc;
            if (cnt_inc == BURST_LEN) begin
              state   <= ST_IDLE;
              o_grant <= {NUM_REQ{1'b0}};
              last    <= gidx;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_grant <= {NUM_REQ{1'b0}};
          cnt     <= {CW{1'b0}};
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_CNT_EN
  // Per-requester wrapping word counters, bumped on each ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_word_cnt <= {(NUM_REQ*16){1'b0}};
    end else begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (o_req_ack[k]) begin
          o_word_cnt[k*16 +: 16] <= o_word_cnt[k*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: a cycle-level behavioural model checked
// on every falling edge, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_fifo_wr_arb;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   ack;
  logic            full = 1'b0;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [NR-1:0]   grant;
  logic            busy;
`ifdef FIFO_WR_ARB_CNT_EN
  logic [NR*16-1:0] word_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: owner index (-1 = idle), words in current burst, last owner.
  int m_owner = -1;
  int m_words = 0;
  int m_last  = NR - 1;
  int m_cnt [NR];
  int grant_log[$];
  int words_log[$];

  always #5 clk = ~clk;

  fifo_wr_arb #(.DATASIZE(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_req_data (req_data),
    .o_req_ack  (ack),
    .i_full     (full),
    .o_wr_en    (wr_en),
    .o_wr_data  (wr_data),
    .o_grant    (grant),
    .o_busy     (busy)
`ifdef FIFO_WR_ARB_CNT_EN
    , .o_word_cnt (word_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs to the model every falling edge, then advance the model.
  always @(negedge clk) begin : cmp
    logic [NR-1:0] e_grant;
    logic [NR-1:0] e_ack;
    logic          e_wr;
    logic [DW-1:0] e_data;
    bit            found;
    int            k;
    if (!rst_n) begin
      m_owner = -1;
      m_words = 0;
      m_last  = NR - 1;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_wr_en", 64'(wr_en), 64'd0);
      check("rst_ack",   64'(ack),   64'd0);
      check("rst_busy",  64'(busy),  64'd0);
    end else begin
      e_grant = '0;
      e_ack   = '0;
      e_wr    = 1'b0;
      e_data  = '0;
      if (m_owner >= 0) begin
        e_grant[m_owner] = 1'b1;
        e_data = req_data[m_owner*DW +: DW];
        e_wr   = req[m_owner] && !full;
        if (e_wr) e_ack[m_owner] = 1'b1;
      end
      check("grant",   64'(grant),   64'(e_grant));
      check("busy",    64'(busy),    64'(m_owner >= 0));
      check("wr_en",   64'(wr_en),   64'(e_wr));
      check("ack",     64'(ack),     64'(e_ack));
      check("wr_data", 64'(wr_data), 64'(e_data));
      if (full && wr_en) check("write_while_full", 64'(wr_en), 64'd0);
`ifdef FIFO_WR_ARB_CNT_EN
      for (int i = 0; i < NR; i++) check("word_cnt", 64'(word_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
      if (m_owner < 0) begin
        found = 1'b0;
        for (int i = 1; i <= NR; i++) begin
          k = (m_last + i) % NR;
          if (!found && req[k]) begin
            found   = 1'b1;
            m_owner = k;
          end
        end
        if (found) begin
          m_words = 0;
          grant_log.push_back(m_owner);
        end
      end else if (!req[m_owner]) begin
        words_log.push_back(m_words);
        m_last  = m_owner;
        m_owner = -1;
      end else if (e_wr) begin
        m_words++;
        m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
        if (m_words == MB) begin
          words_log.push_back(m_words);
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int n_ack;
  logic [63:0] cnt_snap;

  initial begin
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_grant_lit", 64'(grant), 64'd0);
    check("reset_busy_lit",  64'(busy),  64'd0);
    check("reset_wr_lit",    64'(wr_en), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // All four requesting: owners 0,1,2,3,0 with four words each.
    grant_log.delete(); words_log.delete();
    req = 4'b1111;
    repeat (25) tick();
    req = 4'b0000;
    repeat (3) tick();
    check("t1_nbursts", 64'(grant_log.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check("t1_order", 64'(grant_log[i]), 64'(exp_order[i]));
      if (i < words_log.size()) check("t1_words", 64'(words_log[i]), 64'd4);
    end

    // Lone requester 2 with 8'hA5; repeated bursts for the same owner.
    grant_log.delete(); words_log.delete();
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    @(negedge clk);
    check("t2_first_cycle_wr", 64'(wr_en), 64'd0);
    @(negedge clk);
    check("t2_wr_en",   64'(wr_en),   64'd1);
    check("t2_wr_data", 64'(wr_data), 64'hA5);
    check("t2_ack",     64'(ack),     64'b0100);
    tick();
    repeat (10) tick();
    req = 4'b0000;
    repeat (2) tick();
    check("t2_nbursts", 64'(grant_log.size() >= 2), 64'd1);
    if (grant_log.size() >= 2) begin
      check("t2_owner_a", 64'(grant_log[0]), 64'd2);
      check("t2_owner_b", 64'(grant_log[1]), 64'd2);
    end
    if (words_log.size() >= 1) check("t2_words", 64'(words_log[0]), 64'd4);

    // FIFO full for three cycles mid-burst.
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    grant_log.delete(); words_log.delete();
    req = 4'b0001;
    repeat (3) tick();
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t3_stall_no_wr", 64'(wr_en), 64'd0);
      tick();
    end
    full = 1'b0;
    repeat (2) tick();
    req = 4'b0000;
    repeat (2) tick();
    check("t3_nbursts", 64'(words_log.size()), 64'd1);
    if (words_log.size() >= 1) check("t3_words", 64'(words_log[0]), 64'd4);

    // Owner runs dry after two words; next grant goes round-robin.
    grant_log.delete(); words_log.delete();
    req = 4'b1111;
    repeat (3) tick();
    req = 4'b1101;
    @(negedge clk);
    check("t4_drop_no_wr", 64'(wr_en), 64'd0);
    tick();
    @(negedge clk);
    check("t4_idle_busy",  64'(busy),  64'd0);
    check("t4_idle_grant", 64'(grant), 64'd0);
    tick();
    @(negedge clk);
    check("t4_next_grant", 64'(grant), 64'b0100);
    tick();
    req = 4'b0000;
    repeat (3) tick();
    if (grant_log.size() >= 2) begin
      check("t4_owner_a", 64'(grant_log[0]), 64'd1);
      check("t4_owner_b", 64'(grant_log[1]), 64'd2);
    end else begin
      check("t4_nbursts", 64'(grant_log.size()), 64'd2);
    end
    if (words_log.size() >= 1) check("t4_words", 64'(words_log[0]), 64'd2);

    // Reset pulse in mid-burst aborts immediately; requester 0 wins afterwards.
    req = 4'b1111;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_grant", 64'(grant), 64'd0);
    check("t5_rst_wr_en", 64'(wr_en), 64'd0);
    check("t5_rst_ack",   64'(ack),   64'd0);
    tick();
    rst_n = 1'b1;
    grant_log.delete(); words_log.delete();
    @(negedge clk);
    check("t5_idle_busy", 64'(busy), 64'd0);
    tick();
    @(negedge clk);
    check("t5_first_grant", 64'(grant), 64'b0001);
    tick();
    req = 4'b0000;
    repeat (5) tick();
    if (grant_log.size() >= 1) check("t5_model_first", 64'(grant_log[0]), 64'd0);

    // Ten words from requester 1 after a fresh reset.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    req = 4'b0010;
    n_ack = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (ack[1]) n_ack++;
      tick();
    end
    req = 4'b0000;
    repeat (2) tick();
    check("t6_acks", 64'(n_ack), 64'd10);
`ifdef FIFO_WR_ARB_CNT_EN
    cnt_snap = 64'(word_cnt);
    check("t6_cnt_req1",   64'(cnt_snap[31:16]), 64'd10);
    check("t6_cnt_others", {16'd0, cnt_snap[63:32], cnt_snap[15:0]}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, width of one write word.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum words per grant (1..16).
REQ-004 SHALL have port i_clk  input  1  single clock; FIFO write-domain clock.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_req  input  NUM_REQ  per-requester "word available" flag.
REQ-007 SHALL have port i_req_data  input  NUM_REQ*DATASIZE  requester k word at bits [k*DATASIZE +: DATASIZE].
REQ-008 SHALL have port o_req_ack  output  NUM_REQ  one-hot; word of requester k consumed this cycle.
REQ-009 SHALL have port i_full  input  1  FIFO full flag.
REQ-010 SHALL have port o_wr_en  output  1  FIFO write enable.
REQ-011 SHALL have port o_wr_data  output  DATASIZE  FIFO write data.
REQ-012 SHALL have port o_grant  output  NUM_REQ  registered one-hot current owner; all-zero when idle.
REQ-013 SHALL have port o_busy  output  1  high in BURST state.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, BURST.
REQ-015 In IDLE with any i_req high, SHALL select the first requester at or after index last+1 (mod NUM_REQ), register it into o_grant, and enter BURST the next cycle.
REQ-016 In IDLE, o_wr_en and o_req_ack SHALL be 0; request-to-first-write latency is 1 cycle minimum.
REQ-017 In BURST, o_wr_en = i_req[g] & ~i_full, combinationally; o_req_ack[g] equals o_wr_en; all other ack bits 0.
REQ-018 o_wr_data SHALL be the granted requester's word, and all-zero when o_grant is zero.
REQ-019 Burst counter (clog2(MAX_BURST)+1 bits) SHALL clear on grant and increment on each o_wr_en.
REQ-020 BURST SHALL exit to IDLE after the cycle in which the counter reaches MAX_BURST, or in any cycle where i_req[g] is low; on exit, o_grant clears and last <= g.
REQ-021 i_full high SHALL stall the burst (no write, no ack, counter held, grant kept); no word is ever written while i_full is high.
REQ-022 New requests arriving during BURST SHALL NOT preempt the owner.
REQ-023 With a single active requester, repeated grants SHALL continue, with one IDLE cycle between bursts.

Reset
REQ-024 On i_rst_n low, SHALL asynchronously set: state IDLE, o_grant 0, o_busy 0, counter 0, last = NUM_REQ-1 (so requester 0 wins first).
REQ-025 Reset asserted mid-burst SHALL abort the burst; o_wr_en and o_req_ack SHALL fall to 0 in the same cycle.

Configuration
REQ-026 Macro FIFO_WR_ARB_CNT_EN defined: SHALL add output o_word_cnt (NUM_REQ*16 bits), a wrapping 16-bit count per requester, incremented on each of its acks and reset to 0.
REQ-027 Macro undefined: o_word_cnt port and its counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 FSM state encoding and the round-robin search function SHALL live in package fifo_arb_pkg.
REQ-029 Round-robin selection SHALL be one sub-module, rr_pick (inputs req vector and last index; outputs one-hot grant and index), purely combinational.

Verification
REQ-030 After reset, i_req=4'b1111 and i_full=0 -> grants go 0,1,2,3,0, each carrying 4 writes, with a 1-cycle IDLE gap between grants.
REQ-031 Only requester 2 active, data 8'hA5 -> o_wr_en high on the 2nd cycle after i_req rises, o_wr_data=8'hA5, o_req_ack=4'b0100.
REQ-032 i_full high for 3 cycles mid-burst -> no o_wr_en during those cycles; burst resumes and completes exactly 4 words total.
REQ-033 Owner drops i_req after 2 words -> IDLE next cycle; next grant goes to the next requester in round-robin order.
REQ-034 i_rst_n pulsed low mid-burst -> o_grant=0 and o_wr_en=0 immediately; first grant after release goes to requester 0.
REQ-035 FIFO_WR_ARB_CNT_EN defined, 10 words from requester 1 -> o_word_cnt[31:16]=10 and all other counts 0.
